cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Registered round-robin arbiter for the Common Data Bus (CDB), the stage directly downstream of the functional units.
//  - Accepts completion requests from ALU, MUL, DIV and MEM.
//  - Grants one requester per cycle.
//  - Drives a one-cycle registered broadcast (BCEN/BClabel/BCdata) to the register file, reservation stations and operand queues.
//  - Replaces the combinational fixed-priority CDB path.
//  - Rotating priority guarantees no unit starves.
// PARAMETERS
//  N_REQ    4   number of requesting units; bit i = unit i (0 alu, 1 mul, 2 div, 3 mem)
//  DATA_W   32  result width
//  LABEL_W  4   reservation-station label width; label 0 = "no producer"
// PORTS
//  clk       in   1              clock, rising edge
//  RST       in   1              asynchronous, active-high reset
//  require   in   N_REQ          unit i holds a result ready for broadcast
//  data0..3  in   DATA_W         result of unit 0..3; valid while require[i] is high
//  label0..3 in   LABEL_W        producing label of unit 0..3; valid while require[i] is high
//  accept    out  N_REQ          one-hot grant; combinational in the same cycle as require
//  BCEN      out  1              broadcast valid (registered)
//  BClabel   out  LABEL_W        broadcast label (registered)
//  BCdata    out  DATA_W         broadcast data (registered)
// BEHAVIOUR
//  - Reset (async, while RST=1):
//    - BCEN=0, BClabel=0, BCdata=0.
//    - Round-robin pointer rr_ptr=0.
//    - accept forced to 0 regardless of require.
//  - Grant (comb):
//    - Search require starting at index rr_ptr, wrapping modulo N_REQ.
//    - The first set bit wins and accept gets exactly that bit; no request gives accept=0.
//  - Handshake:
//    - Unit i keeps require[i], data_i and label_i stable until it samples accept[i]=1 at a clock edge.
//    - It drops require[i] (or presents its next result) in the following cycle.
//    - accept never asserts for a bit whose require is low.
//  - Latency: grant in cycle T gives BCEN=1 with the granted label/data in cycle T+1, for exactly 1 cycle per grant.
//  - Back-to-back: a new grant each cycle yields continuous BCEN=1 with one broadcast per cycle and no bubble.
//  - Pointer update: on a grant to index g, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds.
//  - Idle cycle (no grant at edge):
//    - BCEN <= 0 and BClabel <= 0, so a stale label cannot match a waiting station.
//    - BCdata holds its last value.
//  - Fairness: a continuously requesting unit is granted within N_REQ cycles.
//  - require with label 0 is granted normally but broadcasts label 0, which matches nothing. Assertion-only warning; no error output.
//  - Reset asserted mid-stream: an in-flight broadcast is dropped; units re-request after reset.
//  - Reset deasserted: the first grant occurs at the first edge with require!=0.
// STRUCTURE
//  - tomasulo_pkg holds:
//    - UNIT_ALU=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_MEM=3.
//    - LABEL_NONE=0.
//    - N_REQ, DATA_W and LABEL_W defaults.
//  - Sub-module rr_picker (combinational):
//    - Input: req and ptr. Output: one-hot gnt and encoded idx.
//    - Implemented as rotate, then priority-encode, then rotate back.
//  - Top level holds rr_ptr, the output registers and the data/label mux selected by idx.
// TESTING
//  1. Reset:
//    - RST=1 with require=4'b1111 gives accept=0, BCEN=0, BClabel=0, BCdata=0.
//    - Release RST: the next edge grants unit 0.
//  2. Single request: require=4'b0010, label1=5, data1=32'hDEAD_BEEF.
//    - accept=4'b0010 in cycle T.
//    - Cycle T+1: BCEN=1, BClabel=5, BCdata=DEADBEEF.
//    - Cycle T+2: BCEN=0, BClabel=0.
//  3. Round robin: require held at 4'b1111 from reset.
//    - Grants follow 0,1,2,3,0 on consecutive cycles.
//    - BCEN stays 1 continuously from the second cycle.
//  4. Wrap and skip: rr_ptr=3 with require=4'b0101 grants unit 0 (wrap), then rr_ptr=1.
//    - Next cycle, require=4'b0100 grants unit 2.
//  5. Starvation: require[3]=1 held while units 0..2 toggle randomly.
//    - Unit 3 is granted within 4 cycles every time (assertion).
//  6. Mid-stream reset: assert RST in the cycle after a grant.
//    - BCEN drops to 0 immediately (async) and rr_ptr=0.
//    - No broadcast is emitted for that grant.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared constants and types for the Tomasulo back end: unit numbering on the
// Common Data Bus, the "no producer" label and default bus widths.
package tomasulo_pkg;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 32;
  localparam int LABEL_W = 4;
  localparam int IDX_W   = $clog2(N_REQ);

  // Label value that no reservation station ever waits on.
  localparam int LABEL_NONE = 0;

  // Requester numbering: bit i of the request vector belongs to unit i.
  typedef enum logic [IDX_W-1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2,
    UNIT_MEM = 2'd3
  } unit_e;

  // Round-robin successor of a granted index, wrapping back to unit 0.
  function automatic logic [IDX_W-1:0] nextPtr(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] result;
    if (idx == IDX_W'(N_REQ - 1)) result = '0;
    else                          result = idx + 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. The request vector is rotated so the
// current priority holder sits at bit 0, the lowest set bit is found, and the
// winning offset is rotated back into an absolute index and one-hot grant.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [2*N-1:0]   w_doubled;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_offset;
  logic             w_found;
  logic [IDX_W:0]   w_sum;

  // Rotating a doubled copy right by the pointer puts request[ptr] at bit 0.
  assign w_doubled = {i_req, i_req} >> i_ptr;
  assign w_rot     = w_doubled[N-1:0];

  // Lowest set bit of the rotated vector is the nearest requester after ptr.
  always_comb begin
    w_offset = '0;
    w_found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_offset = IDX_W'(i);
        w_found  = 1'b1;
      end
    end
  end

  // Undo the rotation: offset + ptr, wrapped modulo N, then decode to one-hot.
  always_comb begin
    w_sum = {1'b0, w_offset} + {1'b0, i_ptr};
    if (w_sum >= (IDX_W + 1)'(N)) o_idx = IDX_W'(w_sum - (IDX_W + 1)'(N));
    else                          o_idx = w_sum[IDX_W-1:0];
    o_valid = w_found;
    if (w_found) o_gnt = {{(N - 1){1'b0}}, 1'b1} << o_idx;
    else         o_gnt = '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered round-robin arbiter for the Common Data Bus. Picks one of the
// ALU/MUL/DIV/MEM completions each cycle, acknowledges it combinationally on
// accept, and broadcasts its label and data for exactly one cycle afterwards.
module cdb_arbiter #(
  parameter int DATA_W  = tomasulo_pkg::DATA_W,
  parameter int LABEL_W = tomasulo_pkg::LABEL_W
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [3:0]         require,
  input  logic [DATA_W-1:0]  data0,
  input  logic [DATA_W-1:0]  data1,
  input  logic [DATA_W-1:0]  data2,
  input  logic [DATA_W-1:0]  data3,
  input  logic [LABEL_W-1:0] label0,
  input  logic [LABEL_W-1:0] label1,
  input  logic [LABEL_W-1:0] label2,
  input  logic [LABEL_W-1:0] label3,
  output logic [3:0]         accept,
  output logic               BCEN,
  output logic [LABEL_W-1:0] BClabel,
  output logic [DATA_W-1:0]  BCdata
);

  import tomasulo_pkg::*;

  logic [IDX_W-1:0]   r_rrPtr;
  logic               r_bcen;
  logic [LABEL_W-1:0] r_bcLabel;
  logic [DATA_W-1:0]  r_bcData;

  logic [N_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_valid;
  logic [DATA_W-1:0]  w_data;
  logic [LABEL_W-1:0] w_label;

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (require),
    .i_ptr   (r_rrPtr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // While reset is held no unit may believe it was accepted.
  assign accept = RST ? '0 : w_gnt;

  // Route the winning unit's label and data towards the broadcast registers.
  always_comb begin
    w_data  = '0;
    w_label = '0;
    case (unit_e'(w_idx))
      UNIT_ALU: begin w_data = data0; w_label = label0; end
      UNIT_MUL: begin w_data = data1; w_label = label1; end
      UNIT_DIV: begin w_data = data2; w_label = label2; end
      UNIT_MEM: begin w_data = data3; w_label = label3; end
      default:  begin w_data = '0;    w_label = '0;     end
    endcase
  end

  // Pointer and broadcast registers; an idle edge clears the label so a stale
  // tag can never wake a station, but data is left alone to save toggling.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_rrPtr   <= '0;
      r_bcen    <= 1'b0;
      r_bcLabel <= '0;
      r_bcData  <= '0;
    end else if (w_valid) begin
      r_rrPtr   <= nextPtr(w_idx);
      r_bcen    <= 1'b1;
      r_bcLabel <= w_label;
      r_bcData  <= w_data;
    end else begin
      r_bcen    <= 1'b0;
      r_bcLabel <= '0;
    end
  end

  assign BCEN    = r_bcen;
  assign BClabel = r_bcLabel;
  assign BCdata  = r_bcData;

  // The grant is at most one unit and only ever a unit that is requesting.
  assert property (@(posedge clk) disable iff (RST)
    $onehot0(accept) && ((accept & ~require) == '0));

  // A label-0 result is legal but its broadcast will wake nobody.
  assert property (@(posedge clk) disable iff (RST)
    (|accept) |-> (w_label != LABEL_W'(LABEL_NONE)))
    else $warning("cdb_arbiter: unit granted with label 0, broadcast matches no station");

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: reset values, a table of directed request patterns
// with hand-computed grants, a mid-stream reset, and a random phase that
// watches the memory unit never waits more than four cycles.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  require = 4'b1111;
  logic [31:0] data0, data1, data2, data3;
  logic [3:0]  label0, label1, label2, label3;
  logic [3:0]  accept;
  logic        BCEN;
  logic [3:0]  BClabel;
  logic [31:0] BCdata;

  logic [31:0] uData [4];
  logic [3:0]  uLabel [4];

  int checks = 0;
  int passes = 0;

  // One directed cycle: request vector, the grant it must produce, per-unit
  // labels packed four bits per unit, and a data base value. Unit i presents
  // dbase with its index XORed into the top nibble.
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  acc;
    logic [15:0] lbls;
    logic [31:0] dbase;
  } vec_t;

  // What the broadcast registers must show one edge after a cycle.
  typedef struct {
    logic        en;
    logic [3:0]  lbl;
    logic [31:0] dat;
  } bc_t;

  bc_t         sbQ [$];
  vec_t        vecs [$];
  logic [31:0] lastData = '0;
  logic [3:0]  lastAcc;

  assign data0  = uData[0];
  assign data1  = uData[1];
  assign data2  = uData[2];
  assign data3  = uData[3];
  assign label0 = uLabel[0];
  assign label1 = uLabel[1];
  assign label2 = uLabel[2];
  assign label3 = uLabel[3];

  cdb_arbiter dut (
    .clk     (clk),
    .RST     (RST),
    .require (require),
    .data0   (data0),
    .data1   (data1),
    .data2   (data2),
    .data3   (data3),
    .label0  (label0),
    .label1  (label1),
    .label2  (label2),
    .label3  (label3),
    .accept  (accept),
    .BCEN    (BCEN),
    .BClabel (BClabel),
    .BCdata  (BCdata)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something upstream of the bench hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [3:0] req, input logic [3:0] acc,
                                 input logic [15:0] lbls, input logic [31:0] dbase);
    vec_t v;
    v.req = req; v.acc = acc; v.lbls = lbls; v.dbase = dbase;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Load every unit's label and data from a table entry.
  task automatic applyStimulus(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      uLabel[i] = v.lbls[4*i +: 4];
      uData[i]  = v.dbase ^ (32'(i) << 28);
    end
  endtask

  // Drive one cycle's requests, check the combinational grant, record the
  // broadcast it implies, then check the registered outputs after the edge.
  task automatic runCycle(input logic [3:0] req, input logic [3:0] expAcc);
    bc_t e;
    bc_t got;
    @(negedge clk);
    require = req;
    #1;
    lastAcc = accept;
    checkOutput("accept", 32'(accept), 32'(expAcc));
    e.en = 1'b0; e.lbl = '0; e.dat = lastData;
    for (int i = 0; i < 4; i++) begin
      if (expAcc[i]) begin
        e.en = 1'b1; e.lbl = uLabel[i]; e.dat = uData[i];
      end
    end
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd1);
    end else begin
      got = sbQ.pop_front();
      checkOutput("BCEN", 32'(BCEN), 32'(got.en));
      checkOutput("BClabel", 32'(BClabel), 32'(got.lbl));
      checkOutput("BCdata", BCdata, got.dat);
      if (got.en) lastData = got.dat;
    end
  endtask

  // Hold reset for two edges with the given requests, then release mid-cycle.
  task automatic holdReset(input logic [3:0] req);
    RST = 1'b1;
    require = req;
    @(posedge clk);
    @(posedge clk);
    #1;
    sbQ.delete();
    lastData = '0;
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #2 RST = 1'b0;
  endtask

  // Main sequence.
  initial begin
    logic [3:0] req;
    logic [3:0] expAcc;
    logic [2:0] pend;
    int mPtr;
    int waitCnt;
    int u;

    applyStimulus(mkVec(4'b0, 4'b0, 16'h4321, 32'h1111_0000));

    // Reset with every unit requesting: nothing may be accepted or broadcast.
    holdReset(4'b1111);
    checkOutput("reset_accept", 32'(accept), 32'd0);
    checkOutput("reset_BCEN", 32'(BCEN), 32'd0);
    checkOutput("reset_BClabel", 32'(BClabel), 32'd0);
    checkOutput("reset_BCdata", BCdata, 32'd0);
    releaseReset();

    // Directed table starting from pointer 0 straight out of reset.
    vecs.push_back(mkVec(4'b1111, 4'b0001, 16'h4321, 32'h1111_0000));
    vecs.push_back(mkVec(4'b1111, 4'b0010, 16'h4321, 32'h1111_0000));
    vecs.push_back(mkVec(4'b1111, 4'b0100, 16'h4321, 32'h1111_0000));
    vecs.push_back(mkVec(4'b1111, 4'b1000, 16'h4321, 32'h1111_0000));
    vecs.push_back(mkVec(4'b1111, 4'b0001, 16'h4321, 32'h0555_1234));
    vecs.push_back(mkVec(4'b0000, 4'b0000, 16'h4321, 32'h0555_1234));
    vecs.push_back(mkVec(4'b0010, 4'b0010, 16'h4351, 32'hCEAD_BEEF));
    vecs.push_back(mkVec(4'b0000, 4'b0000, 16'h4321, 32'h0777_0000));
    vecs.push_back(mkVec(4'b0100, 4'b0100, 16'h4321, 32'h0222_0000));
    vecs.push_back(mkVec(4'b0101, 4'b0001, 16'h4321, 32'h0222_0000));
    vecs.push_back(mkVec(4'b0100, 4'b0100, 16'h4321, 32'h0222_0000));
    vecs.push_back(mkVec(4'b1010, 4'b1000, 16'h9876, 32'h0333_0000));
    vecs.push_back(mkVec(4'b1010, 4'b0010, 16'h9876, 32'h0333_0000));
    vecs.push_back(mkVec(4'b0001, 4'b0001, 16'hABCD, 32'h0444_5555));
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      runCycle(vecs[k].req, vecs[k].acc);
    end

    // Pointer is now 1: grant unit 1, then reset while its broadcast is live.
    applyStimulus(mkVec(4'b0, 4'b0, 16'h4321, 32'h0666_0000));
    runCycle(4'b1111, 4'b0010);
    #1 RST = 1'b1;
    #1;
    checkOutput("midreset_BCEN", 32'(BCEN), 32'd0);
    checkOutput("midreset_BClabel", 32'(BClabel), 32'd0);
    checkOutput("midreset_BCdata", BCdata, 32'd0);
    checkOutput("midreset_accept", 32'(accept), 32'd0);
    sbQ.delete();
    lastData = '0;
    @(posedge clk);
    #1;
    checkOutput("midreset_hold_BCEN", 32'(BCEN), 32'd0);
    releaseReset();
    runCycle(4'b1111, 4'b0001);

    // Random phase: memory unit always requesting, others toggle while obeying
    // the hold-until-accepted handshake. Grants come from a search model.
    holdReset(4'b0000);
    releaseReset();
    pend = 3'b000;
    mPtr = 0;
    waitCnt = 0;
    for (int c = 0; c < 160; c++) begin
      req = {1'b1, pend};
      expAcc = '0;
      for (int k = 0; k < 4; k++) begin
        u = (mPtr + k) % 4;
        if (expAcc == 4'b0000 && req[u]) expAcc[u] = 1'b1;
      end
      runCycle(req, expAcc);
      for (int k = 0; k < 4; k++) if (expAcc[k]) mPtr = (k + 1) % 4;
      waitCnt++;
      if (lastAcc[3] || waitCnt > 4) begin
        checks++;
        if (lastAcc[3] && waitCnt <= 4) passes++;
        else $display("[TB] FAIL starvation: unit 3 waited %0d cycles, limit 4", waitCnt);
        waitCnt = 0;
      end
      for (int i = 0; i < 3; i++) begin
        if (expAcc[i] || !pend[i]) begin
          pend[i]   = 1'($urandom_range(0, 1));
          uData[i]  = $urandom;
          uLabel[i] = 4'($urandom_range(1, 15));
        end
      end
      if (expAcc[3]) begin
        uData[3]  = $urandom;
        uLabel[3] = 4'($urandom_range(1, 15));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
